bus_arb4: RTL and testbench

BUS_ARB4 -- requirements
Module: bus_arb4

---
 rtl/bus_arb4.sv | 129 ++++++++++++
 tb/tb_bus_arb4.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/bus_arb4.sv
// bus_arb4: four-requester round-robin bus arbiter with a hold limit per grant.
// A grant is always followed by one dead cycle before the bus changes hands.
module bus_arb4 #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MAXHOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [3:0]       gnt,
  output logic [1:0]       gnt_idx,
  output logic             gnt_valid,
  output logic [WIDTH-1:0] dout
);

  typedef enum logic [1:0] {StIdle, StOwned, StTurn} state_e;

  // Last legal value of the hold counter before preemption; unused when MAXHOLD is 0.
  localparam logic [7:0] HoldLast = (MAXHOLD == 0) ? 8'd0 : 8'(MAXHOLD - 1);
  localparam bit         HoldLim  = (MAXHOLD != 0);

  state_e     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic       valid_q, valid_d;

  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] cand;

  // Rotating priority: first requester found scanning from ptr upward, mod 4.
  always_comb begin
    win_found = 1'b0;
    win_idx   = ptr_q;
    cand      = ptr_q;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hcnt_d  = hcnt_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    case (state_q)
      StIdle, StTurn: begin
        if (win_found) begin
          state_d = StOwned;
          gnt_d   = 4'b0001 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hcnt_d  = 8'd0;
        end else begin
          state_d = StIdle;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
        end
      end
      StOwned: begin
        if (!req[idx_q] || (HoldLim && (hcnt_q == HoldLast))) begin
          // Release or preempt; pointer moves past the owner so it gets lowest priority.
          state_d = StTurn;
          gnt_d   = 4'b0000;
          valid_d = 1'b0;
          ptr_d   = idx_q + 2'd1;
        end else if (hcnt_q != 8'hFF) begin
          hcnt_d = hcnt_q + 8'd1;
        end
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= 2'd0;
      hcnt_q  <= 8'd0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hcnt_q  <= hcnt_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

  // Data mux driven from the registered select; zero when nobody owns the bus.
  always_comb begin
    dout = '0;
    if (valid_q) begin
      unique case (idx_q)
        2'd0: dout = in0;
        2'd1: dout = in1;
        2'd2: dout = in2;
        2'd3: dout = in3;
        default: dout = '0;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_bus_arb4.sv
// tb_bus_arb4: directed stimulus with a per-cycle expectation queue, checked by a monitor.
// Four arbiters with different MAXHOLD share clock, reset and inputs; each entry names one.
module tb_bus_arb4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [31:0] in_v [4];

  logic [3:0]  g  [4];
  logic [1:0]  gi [4];
  logic        gv [4];
  logic [31:0] dd [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0] sel;  // 0: MAXHOLD=16, 1: MAXHOLD=2, 2: MAXHOLD=3, 3: MAXHOLD=0
    logic [3:0] gnt;
    logic [1:0] idx;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  initial begin
    in_v[0] = 32'hA000_0001;
    in_v[1] = 32'hB000_0012;
    in_v[2] = 32'hC000_0123;
    in_v[3] = 32'hD000_1234;
  end

  bus_arb4 #(.WIDTH(32), .MAXHOLD(16)) u_d16 (
    .clk(clk), .rst(rst), .req(req),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .gnt(g[0]), .gnt_idx(gi[0]), .gnt_valid(gv[0]), .dout(dd[0])
  );
  bus_arb4 #(.WIDTH(32), .MAXHOLD(2)) u_d2 (
    .clk(clk), .rst(rst), .req(req),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .gnt(g[1]), .gnt_idx(gi[1]), .gnt_valid(gv[1]), .dout(dd[1])
  );
  bus_arb4 #(.WIDTH(32), .MAXHOLD(3)) u_d3 (
    .clk(clk), .rst(rst), .req(req),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .gnt(g[2]), .gnt_idx(gi[2]), .gnt_valid(gv[2]), .dout(dd[2])
  );
  bus_arb4 #(.WIDTH(32), .MAXHOLD(0)) u_d0 (
    .clk(clk), .rst(rst), .req(req),
    .in0(in_v[0]), .in1(in_v[1]), .in2(in_v[2]), .in3(in_v[3]),
    .gnt(g[3]), .gnt_idx(gi[3]), .gnt_valid(gv[3]), .dout(dd[3])
  );

  // Drive one cycle of inputs, let the edge take them, then queue the expected outputs.
  task automatic cyc(input logic [3:0] r, input logic rs, input logic [1:0] s,
                     input logic [3:0] eg, input logic [1:0] ei, input string t);
    exp_t e;
    req = r;
    rst = rs;
    @(posedge clk);
    #1;
    e.sel = s;
    e.gnt = eg;
    e.idx = ei;
    e.tag = t;
    exp_q.push_back(e);
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t        e;
    logic        ev;
    logic [31:0] ed;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        ev = |e.gnt;
        ed = ev ? in_v[e.idx] : 32'h0;
        checks++;
        if (g[e.sel] !== e.gnt || gi[e.sel] !== e.idx || gv[e.sel] !== ev ||
            dd[e.sel] !== ed) begin
          errors++;
          $display("FAIL %s dut%0d: got gnt=%b idx=%0d valid=%b dout=%h, want gnt=%b idx=%0d valid=%b dout=%h",
                   e.tag, e.sel, g[e.sel], gi[e.sel], gv[e.sel], dd[e.sel],
                   e.gnt, e.idx, ev, ed);
        end
      end
    end
  end

  initial begin
    logic [3:0] sg [8];
    logic [1:0] si [8];
    int         owner;

    // Reset with every requester asserted: requests must be ignored.
    cyc(4'b1111, 1'b1, 2'd0, 4'b0000, 2'd0, "rst_hold");
    cyc(4'b1111, 1'b1, 2'd3, 4'b0000, 2'd0, "rst_hold0");
    cyc(4'b0000, 1'b0, 2'd0, 4'b0000, 2'd0, "idle_after_rst");

    // Single requester 2: one-cycle latency, release, dead cycle, idle.
    cyc(4'b0100, 1'b0, 2'd0, 4'b0100, 2'd2, "a_grant");
    cyc(4'b0100, 1'b0, 2'd0, 4'b0100, 2'd2, "a_hold1");
    cyc(4'b0100, 1'b0, 2'd0, 4'b0100, 2'd2, "a_hold2");
    cyc(4'b0000, 1'b0, 2'd0, 4'b0000, 2'd2, "a_turn");
    cyc(4'b0000, 1'b0, 2'd0, 4'b0000, 2'd2, "a_idle");

    // All requesting, MAXHOLD=2: 0,0,-,1,1,-,2,2,-,3,3,-,0
    cyc(4'b0000, 1'b1, 2'd1, 4'b0000, 2'd0, "b_rst");
    for (int k = 0; k < 13; k++) begin
      owner = (k / 3) % 4;
      if (k % 3 == 2) cyc(4'b1111, 1'b0, 2'd1, 4'b0000, 2'(owner), "b_dead");
      else            cyc(4'b1111, 1'b0, 2'd1, 4'b0001 << owner, 2'(owner), "b_grant");
    end

    // Sole requester 0, MAXHOLD=3: three cycles, dead cycle, regrant.
    cyc(4'b0000, 1'b1, 2'd2, 4'b0000, 2'd0, "c_rst");
    for (int k = 0; k < 12; k++) begin
      if (k % 4 == 3) cyc(4'b0001, 1'b0, 2'd2, 4'b0000, 2'd0, "c_dead");
      else            cyc(4'b0001, 1'b0, 2'd2, 4'b0001, 2'd0, "c_grant");
    end

    // Preempted owner competes last: req=0011, MAXHOLD=2 -> 0,0,-,1,1,-,0,0
    cyc(4'b0000, 1'b1, 2'd1, 4'b0000, 2'd0, "r_rst");
    sg = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0001, 4'b0001};
    si = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
    for (int k = 0; k < 8; k++) cyc(4'b0011, 1'b0, 2'd1, sg[k], si[k], "r_rotate");

    // Hold limit 16: exactly 16 owned cycles, one dead cycle, regrant.
    cyc(4'b0000, 1'b1, 2'd0, 4'b0000, 2'd0, "h_rst");
    for (int k = 0; k < 18; k++) begin
      if (k == 16) cyc(4'b0001, 1'b0, 2'd0, 4'b0000, 2'd0, "h_preempt");
      else         cyc(4'b0001, 1'b0, 2'd0, 4'b0001, 2'd0, "h_grant");
    end

    // Owner 1, requester 3 arrives mid-grant and waits for release.
    cyc(4'b0000, 1'b1, 2'd0, 4'b0000, 2'd0, "d_rst");
    cyc(4'b0010, 1'b0, 2'd0, 4'b0010, 2'd1, "d_grant1");
    cyc(4'b0010, 1'b0, 2'd0, 4'b0010, 2'd1, "d_hold");
    for (int k = 0; k < 3; k++) cyc(4'b1010, 1'b0, 2'd0, 4'b0010, 2'd1, "d_ignore3");
    cyc(4'b1000, 1'b0, 2'd0, 4'b0000, 2'd1, "d_turn");
    cyc(4'b1000, 1'b0, 2'd0, 4'b1000, 2'd3, "d_grant3");
    cyc(4'b1000, 1'b0, 2'd0, 4'b1000, 2'd3, "d_hold3");

    // Pointer wraps 3->0, then reset mid-grant and regrant from ptr=0.
    cyc(4'b0000, 1'b0, 2'd0, 4'b0000, 2'd3, "e_turn");
    cyc(4'b0010, 1'b0, 2'd0, 4'b0010, 2'd1, "e_wrap_grant1");
    cyc(4'b1010, 1'b1, 2'd0, 4'b0000, 2'd0, "e_rst_mid");
    cyc(4'b1010, 1'b0, 2'd0, 4'b0010, 2'd1, "e_regrant1");
    cyc(4'b1010, 1'b0, 2'd0, 4'b0010, 2'd1, "e_hold");

    // Unlimited hold: requester 0 keeps the bus for 300 cycles.
    cyc(4'b0000, 1'b1, 2'd3, 4'b0000, 2'd0, "f_rst");
    for (int k = 0; k < 300; k++) cyc(4'b0011, 1'b0, 2'd3, 4'b0001, 2'd0, "f_own");
    checks++;
    if (u_d0.hcnt_q !== 8'd255) begin
      errors++;
      $display("FAIL f_hcnt_sat: got hcnt=%0d, want 255", u_d0.hcnt_q);
    end
    cyc(4'b0010, 1'b0, 2'd3, 4'b0000, 2'd0, "f_release");
    cyc(4'b0010, 1'b0, 2'd3, 4'b0010, 2'd1, "f_grant1");

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
